// File: rtl/adc_sequencer_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Holds the FSM state encoding, channel-index width and accumulator sizing.
package adc_seq_pkg;

  localparam int CHAN_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERIOD,
    S_ISSUE,
    S_WAIT_DATA,
    S_NEXT
  } state_t;

  // Summing 2^os_log2 samples of data_w bits needs exactly os_log2 extra bits.
  function automatic int acc_width(input int data_w, input int os_log2);
    return data_w + os_log2;
  endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// Bus between the scan sequencer (master), its ADC core and its result consumers.
// Signal names follow the core's own naming; the sequencer drives the request and result side.
interface adc_sequencer_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 12
);

  logic                              enable;
  logic [NUM_CHANNELS-1:0]           chan_mask;
  logic [15:0]                       period;
  logic                              conv_ready;
  logic                              conv_start;
  logic [adc_seq_pkg::CHAN_W-1:0]    conv_channel;
  logic                              adc_valid;
  logic [adc_seq_pkg::CHAN_W-1:0]    adc_channel;
  logic [DATA_WIDTH-1:0]             adc_data;
  logic                              result_valid;
  logic [adc_seq_pkg::CHAN_W-1:0]    result_channel;
  logic [DATA_WIDTH-1:0]             result_data;
  logic                              scan_done;
  logic                              overrun;
  logic                              timeout_err;

  modport master (
    input  enable, chan_mask, period, conv_ready, adc_valid, adc_channel, adc_data,
    output conv_start, conv_channel, result_valid, result_channel, result_data,
           scan_done, overrun, timeout_err
  );

  modport slave (
    output enable, chan_mask, period, conv_ready, adc_valid, adc_channel, adc_data,
    input  conv_start, conv_channel, result_valid, result_channel, result_data,
           scan_done, overrun, timeout_err
  );

endinterface

// File: rtl/adc_sequencer_chan_picker.sv
// Finds the lowest set mask bit strictly above i_index, or the lowest set bit
// overall when i_from_start is high.
module adc_chan_picker
  import adc_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 8
) (
  input  logic [NUM_CHANNELS-1:0] i_mask,
  input  logic [CHAN_W-1:0]       i_index,
  input  logic                    i_from_start,
  output logic                    o_found,
  output logic [CHAN_W-1:0]       o_index
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_found = 1'b0;
    o_index = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || i > int'(i_index))) begin
        o_found = 1'b1;
        o_index = CHAN_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Periodic scan controller: walks enabled channels, oversamples each one through
// the ADC core and publishes one averaged result per channel.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 12,
  parameter int OS_LOG2      = 2,
  parameter int TIMEOUT      = 1023
) (
  input logic             clk,
  input logic             reset_n,
  adc_sequencer_if.master bus
);

  localparam int ACC_W = acc_width(DATA_WIDTH, OS_LOG2);
  localparam int CNT_W = (OS_LOG2 > 0) ? OS_LOG2 : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << OS_LOG2) - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

  state_t                  r_state;
  logic [NUM_CHANNELS-1:0] r_mask_snap;
  logic [CHAN_W-1:0]       r_chan;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [15:0]             r_period_cnt;
  logic                    r_period_nz;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_conv_start;
  logic                    r_result_valid;
  logic [CHAN_W-1:0]       r_result_channel;
  logic [DATA_WIDTH-1:0]   r_result_data;
  logic                    r_scan_done;
  logic                    r_overrun;
  logic                    r_timeout_err;

  logic                    w_first_found;
  logic [CHAN_W-1:0]       w_first_idx;
  logic                    w_next_found;
  logic [CHAN_W-1:0]       w_next_idx;
  logic                    w_match;
  logic                    w_timeout;
  logic                    w_last_sample;
  logic [ACC_W-1:0]        w_acc_sum;

  // The scan-start search runs on the live mask; the in-scan search on the snapshot.
  adc_chan_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_first_pick (
    .i_mask       (bus.chan_mask),
    .i_index      ({CHAN_W{1'b0}}),
    .i_from_start (1'b1),
    .o_found      (w_first_found),
    .o_index      (w_first_idx)
  );

  adc_chan_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_next_pick (
    .i_mask       (r_mask_snap),
    .i_index      (r_chan),
    .i_from_start (1'b0),
    .o_found      (w_next_found),
    .o_index      (w_next_idx)
  );

  assign w_match       = bus.adc_valid && (bus.adc_channel == r_chan);
  assign w_acc_sum     = r_acc + ACC_W'(bus.adc_data);
  assign w_last_sample = (r_cnt == LAST_CNT);
  // The conv_start cycle itself is not counted toward the timeout.
  assign w_timeout     = !r_conv_start && (r_to_cnt == LAST_TO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_mask_snap      <= '0;
      r_chan           <= '0;
      r_acc            <= '0;
      r_cnt            <= '0;
      r_period_cnt     <= '0;
      r_period_nz      <= 1'b0;
      r_to_cnt         <= '0;
      r_conv_start     <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_channel <= '0;
      r_result_data    <= '0;
      r_scan_done      <= 1'b0;
      r_overrun        <= 1'b0;
      r_timeout_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; a later assignment in the same edge overrides these defaults.
      r_conv_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_scan_done    <= 1'b0;
      if (r_period_cnt != 16'd0) r_period_cnt <= r_period_cnt - 16'd1;
      if (!bus.enable) begin
        r_overrun     <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      unique case (r_state)
        S_IDLE, S_WAIT_PERIOD: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (r_state == S_IDLE || r_period_cnt <= 16'd1) begin
            if (w_first_found) begin
              r_state      <= S_ISSUE;
              r_mask_snap  <= bus.chan_mask;
              r_chan       <= w_first_idx;
              r_period_cnt <= bus.period;
              r_period_nz  <= (bus.period != 16'd0);
              r_acc        <= '0;
              r_cnt        <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_ISSUE: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (bus.conv_ready) begin
            r_conv_start <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (w_match) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 1'b1;
            if (!bus.enable) begin
              r_state <= S_IDLE;
            end else if (!w_last_sample) begin
              r_state <= S_ISSUE;
            end else begin
              r_result_valid   <= 1'b1;
              r_result_channel <= r_chan;
              r_result_data    <= w_acc_sum[ACC_W-1 -: DATA_WIDTH];
              r_state          <= S_NEXT;
            end
          end else if (w_timeout) begin
            if (bus.enable) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_NEXT;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (!r_conv_start) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_NEXT: begin
          r_acc <= '0;
          r_cnt <= '0;
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (w_next_found) begin
            r_chan  <= w_next_idx;
            r_state <= S_ISSUE;
          end else begin
            r_scan_done <= 1'b1;
            if (r_period_cnt == 16'd0 && r_period_nz) r_overrun <= 1'b1;
            r_state <= S_WAIT_PERIOD;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.conv_start     = r_conv_start;
  assign bus.conv_channel   = r_chan;
  assign bus.result_valid   = r_result_valid;
  assign bus.result_channel = r_result_channel;
  assign bus.result_data    = r_result_data;
  assign bus.scan_done      = r_scan_done;
  assign bus.overrun        = r_overrun;
  assign bus.timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: behavioural ADC core model plus a result scoreboard.
module tb_adc_sequencer;

  localparam int NCH = 8;
  localparam int DW  = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  adc_sequencer_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus ();

  adc_sequencer #(
    .NUM_CHANNELS (NCH),
    .DATA_WIDTH   (DW),
    .OS_LOG2      (2),
    .TIMEOUT      (1023)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   conv_cycles[$];
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   conv_count = 0;
  int   scan_done_count = 0;
  int   last_done_cyc = 0;
  int   lat = 3;
  int   drop_ch = -1;
  int   bad_tag_ch = -1;
  bit   use_seq = 1'b0;
  int   seq_idx = 0;
  int   seq_vals[4];
  int   t_err;
  int   t_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counters();
    conv_count      = 0;
    scan_done_count = 0;
    seq_idx         = 0;
    conv_cycles.delete();
  endtask

  task automatic wait_scans(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && scan_done_count < target; i++) @(negedge clk);
    check(tag, scan_done_count, target);
  endtask

  task automatic wait_conv(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && conv_count < target; i++) @(negedge clk);
    check(tag, 32'(conv_count >= target), 1);
  endtask

  // ADC core model: one outstanding conversion, answers after lat cycles.
  initial begin : core_model
    logic [3:0] ch;
    bus.adc_valid   = 1'b0;
    bus.adc_channel = '0;
    bus.adc_data    = '0;
    forever begin
      @(negedge clk);
      if (bus.conv_start === 1'b1) begin
        ch = bus.conv_channel;
        conv_count++;
        conv_cycles.push_back(cyc);
        if (int'(ch) != drop_ch) begin
          repeat (lat) @(posedge clk);
          if (int'(ch) == bad_tag_ch) begin
            #1;
            bus.adc_valid   = 1'b1;
            bus.adc_channel = 4'd5;
            bus.adc_data    = 12'd4000;
            @(posedge clk);
            #1;
            bus.adc_valid = 1'b0;
            repeat (2) @(posedge clk);
          end
          #1;
          bus.adc_valid   = 1'b1;
          bus.adc_channel = ch;
          bus.adc_data    = use_seq ? 12'(seq_vals[seq_idx % 4]) : 12'(100 + int'(ch));
          seq_idx++;
          @(posedge clk);
          #1;
          bus.adc_valid = 1'b0;
        end
      end
    end
  end

  initial begin : result_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_result_valid", 32'(bus.result_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("result_channel", 32'(bus.result_channel), e.ch);
          check("result_data", 32'(bus.result_data), e.data);
        end
      end
      if (bus.scan_done === 1'b1) begin
        scan_done_count++;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin : main
    bus.enable     = 1'b0;
    bus.chan_mask  = '0;
    bus.period     = '0;
    bus.conv_ready = 1'b1;
    seq_vals       = '{1, 2, 3, 5};

    repeat (3) @(negedge clk);
    check("rst_conv_start", 32'(bus.conv_start), 0);
    check("rst_conv_channel", 32'(bus.conv_channel), 0);
    check("rst_result_valid", 32'(bus.result_valid), 0);
    check("rst_result_data", 32'(bus.result_data), 0);
    check("rst_scan_done", 32'(bus.scan_done), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    reset_n = 1'b1;
    idle(2);

    // Two scans over ch0 and ch2, period long enough to avoid overrun.
    bus.chan_mask = 8'b0000_0101;
    bus.period    = 16'd300;
    lat           = 3;
    clear_counters();
    push_exp(0, 100); push_exp(2, 102); push_exp(0, 100); push_exp(2, 102);
    bus.enable = 1'b1;
    wait_scans("t1_scan1_done", 1, 400);
    check("t1_conv_count_scan1", conv_count, 8);
    check("t1_results_left_after_scan1", exp_q.size(), 2);
    wait_scans("t1_scan2_done", 2, 600);
    bus.enable = 1'b0;
    check("t1_conv_count", conv_count, 16);
    check("t1_period_interval", (conv_cycles.size() > 8) ? conv_cycles[8] - conv_cycles[0] : -1, 300);
    check("t1_overrun", 32'(bus.overrun), 0);
    check("t1_queue_empty", exp_q.size(), 0);
    idle(10);

    // Averaging: samples 1,2,3,5 on ch1 give 11 >> 2 = 2.
    bus.chan_mask = 8'b0000_0010;
    use_seq       = 1'b1;
    clear_counters();
    push_exp(1, 2);
    bus.enable = 1'b1;
    wait_scans("t2_scan_done", 1, 200);
    bus.enable = 1'b0;
    use_seq    = 1'b0;
    check("t2_conv_count", conv_count, 4);
    check("t2_queue_empty", exp_q.size(), 0);
    idle(10);

    // Overrun: period 50, scan takes about 80 cycles.
    bus.chan_mask = 8'b0000_0101;
    bus.period    = 16'd50;
    lat           = 8;
    clear_counters();
    push_exp(0, 100); push_exp(2, 102); push_exp(0, 100); push_exp(2, 102);
    bus.enable = 1'b1;
    wait_scans("t3_scan1_done", 1, 300);
    t_done = last_done_cyc;
    idle(1);
    check("t3_overrun_set", 32'(bus.overrun), 1);
    wait_conv("t3_scan2_started", 9, 50);
    check("t3_restart_latency", (conv_cycles.size() > 8) ? conv_cycles[8] - t_done : -1, 2);
    wait_scans("t3_scan2_done", 2, 300);
    bus.enable = 1'b0;
    idle(2);
    check("t3_overrun_cleared", 32'(bus.overrun), 0);
    check("t3_queue_empty", exp_q.size(), 0);
    idle(10);

    // Timeout on ch3; ch4 still converted.
    bus.chan_mask = 8'b0001_1000;
    bus.period    = 16'd3000;
    lat           = 3;
    drop_ch       = 3;
    clear_counters();
    push_exp(4, 104);
    bus.enable = 1'b1;
    for (int i = 0; i < 1200 && bus.timeout_err !== 1'b1; i++) @(negedge clk);
    t_err = cyc;
    check("t4_timeout_latency", (conv_cycles.size() > 0) ? t_err - conv_cycles[0] : -1, 1024);
    wait_scans("t4_scan_done", 1, 100);
    check("t4_conv_count", conv_count, 5);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_timeout_sticky", 32'(bus.timeout_err), 1);
    bus.enable = 1'b0;
    idle(2);
    check("t4_timeout_cleared", 32'(bus.timeout_err), 0);
    drop_ch = -1;
    idle(10);

    // Mismatched tag 5 while waiting on ch2 is ignored.
    bus.chan_mask = 8'b0000_0100;
    bus.period    = 16'd300;
    bad_tag_ch    = 2;
    clear_counters();
    push_exp(2, 102);
    bus.enable = 1'b1;
    wait_scans("t5_scan_done", 1, 200);
    bus.enable = 1'b0;
    bad_tag_ch = -1;
    check("t5_conv_count", conv_count, 4);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_no_timeout", 32'(bus.timeout_err), 0);
    idle(10);

    // enable falls during WAIT_DATA: no result, then a clean restart from IDLE.
    bus.chan_mask = 8'b0000_0001;
    lat           = 20;
    clear_counters();
    bus.enable = 1'b1;
    wait_conv("t6_conv_issued", 1, 20);
    idle(3);
    bus.enable = 1'b0;
    idle(30);
    check("t6_no_reissue", conv_count, 1);
    check("t6_no_scan_done", scan_done_count, 0);
    lat = 3;
    push_exp(0, 100);
    bus.enable = 1'b1;
    wait_scans("t6_restart_from_idle", 1, 150);
    bus.enable = 1'b0;
    check("t6_queue_empty", exp_q.size(), 0);
    idle(10);

    // reset_n pulsed mid-scan while ch2 is outstanding.
    bus.chan_mask = 8'b0000_0101;
    lat           = 6;
    clear_counters();
    push_exp(0, 100);
    bus.enable = 1'b1;
    wait_conv("t7_reached_ch2", 5, 100);
    idle(1);
    check("t7_pre_rst_channel", 32'(bus.conv_channel), 2);
    #2;
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("t7_rst_conv_channel", 32'(bus.conv_channel), 0);
    check("t7_rst_conv_start", 32'(bus.conv_start), 0);
    check("t7_rst_result_valid", 32'(bus.result_valid), 0);
    check("t7_rst_result_data", 32'(bus.result_data), 0);
    check("t7_rst_scan_done", 32'(bus.scan_done), 0);
    idle(3);
    reset_n = 1'b1;
    idle(20);
    check("t7_no_conv_after_reset", conv_count, 5);
    check("t7_no_scan_done", scan_done_count, 0);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", errors);
    $fatal(1);
  end

endmodule
